// File: rtl/note_tone_pwm.sv
// note_tone_pwm
// -------------
// Mono audio transmit path. One note is picked from a 7-bit key vector
// (C4..B4), a square wave is generated at its pitch, and the wave is
// encoded as 8-bit PWM. Inputs are sampled only once per 256-clock PWM frame.
//
// Ports:
//   clk_in          system clock (100 MHz)
//   rst_in          synchronous, active-low reset
//   enable_in       1 = audio on / amplifier enabled
//   note_in[6:0]    key vector, bit i = note i (0=C4 .. 6=B4); lowest set bit wins
//   vol_in[6:0]     amplitude 0..127
//   aud_pwm         PWM audio output, registered
//   aud_sd          amplifier enable, registered copy of enable_in
//   note_valid_out  a note is being sounded
//   note_idx_out    index of the sounded note, 0 when none
module note_tone_pwm #(
    parameter int CLK_HZ = 100_000_000,
    parameter int HALF_W = 18
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [6:0] note_in,
    input  logic [6:0] vol_in,
    output logic       aud_pwm,
    output logic       aud_sd,
    output logic       note_valid_out,
    output logic [2:0] note_idx_out
);

    // The half-period table below is fixed for a 100 MHz clock; a different
    // CLK_HZ is accepted but does not retune the pitches.
    if (CLK_HZ != 100_000_000) begin : g_table_assumes_100mhz
    end

    // Index of the lowest set key; 0 when no key is set.
    function automatic logic [2:0] lowest_set(input logic [6:0] keys);
        casez (keys)
            7'b??????1: lowest_set = 3'd0;
            7'b?????10: lowest_set = 3'd1;
            7'b????100: lowest_set = 3'd2;
            7'b???1000: lowest_set = 3'd3;
            7'b??10000: lowest_set = 3'd4;
            7'b?100000: lowest_set = 3'd5;
            7'b1000000: lowest_set = 3'd6;
            default:    lowest_set = 3'd0;
        endcase
    endfunction

    // Terminal value of the half-period counter (half period minus one).
    function automatic logic [HALF_W-1:0] half_last(input logic [2:0] idx);
        case (idx)
            3'd0:    half_last = HALF_W'(32'd191109);
            3'd1:    half_last = HALF_W'(32'd170264);
            3'd2:    half_last = HALF_W'(32'd151684);
            3'd3:    half_last = HALF_W'(32'd143171);
            3'd4:    half_last = HALF_W'(32'd127550);
            3'd5:    half_last = HALF_W'(32'd113635);
            3'd6:    half_last = HALF_W'(32'd101238);
            default: half_last = HALF_W'(32'd191109);
        endcase
    endfunction

    logic [7:0]        pwm_cnt_q,  pwm_cnt_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic              sq_q,       sq_d;
    logic [7:0]        level_q,    level_d;
    logic [6:0]        vol_q,      vol_d;
    logic              valid_q,    valid_d;
    logic [2:0]        idx_q,      idx_d;
    logic              aud_pwm_q,  aud_pwm_d;
    logic              aud_sd_q,   aud_sd_d;

    logic              fb_s;
    logic              sel_valid_s;
    logic [2:0]        sel_idx_s;
    logic              restart_s;

    // Frame-boundary note selection and next-state for all registers.
    always_comb begin
        fb_s        = (pwm_cnt_q == 8'd255);
        sel_valid_s = enable_in && (note_in != 7'd0);
        sel_idx_s   = sel_valid_s ? lowest_set(note_in) : 3'd0;
        // Index is forced to 0 when invalid, so one compare covers both
        // index changes and valid<->invalid transitions.
        restart_s   = fb_s && ({sel_valid_s, sel_idx_s} != {valid_q, idx_q});

        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        half_cnt_d = half_cnt_q;
        sq_d       = sq_q;
        level_d    = level_q;
        vol_d      = vol_q;
        valid_d    = valid_q;
        idx_d      = idx_q;

        // Tone generator: a restart has priority over a coincident toggle.
        if (restart_s) begin
            half_cnt_d = '0;
            sq_d       = 1'b1;
        end else if (valid_q) begin
            if (half_cnt_q == half_last(idx_q)) begin
                half_cnt_d = '0;
                sq_d       = ~sq_q;
            end else begin
                half_cnt_d = half_cnt_q + HALF_W'(32'd1);
            end
        end else begin
            half_cnt_d = '0;
            sq_d       = 1'b1;
        end

        // Level uses the pre-edge note state and the volume stored on the
        // previous boundary, so one frame always carries one constant level.
        if (fb_s) begin
            valid_d = sel_valid_s;
            idx_d   = sel_idx_s;
            vol_d   = vol_in;
            if (valid_q) begin
                level_d = sq_q ? (8'd128 + {1'b0, vol_q}) : (8'd128 - {1'b0, vol_q});
            end else begin
                level_d = 8'd128;
            end
        end else begin
            valid_d = valid_q;
            idx_d   = idx_q;
        end

        aud_pwm_d = (pwm_cnt_q < level_q);
        aud_sd_d  = enable_in;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pwm_cnt_q  <= 8'd0;
            half_cnt_q <= '0;
            sq_q       <= 1'b1;
            level_q    <= 8'd128;
            vol_q      <= 7'd0;
            valid_q    <= 1'b0;
            idx_q      <= 3'd0;
            aud_pwm_q  <= 1'b0;
            aud_sd_q   <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            half_cnt_q <= half_cnt_d;
            sq_q       <= sq_d;
            level_q    <= level_d;
            vol_q      <= vol_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            aud_pwm_q  <= aud_pwm_d;
            aud_sd_q   <= aud_sd_d;
        end
    end

    assign aud_pwm        = aud_pwm_q;
    assign aud_sd         = aud_sd_q;
    assign note_valid_out = valid_q;
    assign note_idx_out   = idx_q;

endmodule
